// File: rtl/ram_pkg.sv
// ram_pkg: sweep FSM state type and byte-lane merge helper shared by the RAM files
package ram_pkg;
    typedef enum logic {CLEAR, READY} ram_state_t;
    localparam int MAX_W = 1024;
    function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w, input logic [MAX_W-1:0] mask);
        return (old_w & ~mask) | (new_w & mask);
    endfunction
endpackage

// File: rtl/ram_init_fsm.sv
// ram_init_fsm: walks every address once after reset so the array can be written with the init word
module ram_init_fsm import ram_pkg::*; #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              gen_reset_n,
    output logic              busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
    ram_state_t state, state_nx;
    logic [ADDR_W:0] clr_ptr, ptr_nx;
    always_ff @(posedge clk) begin
        if (!gen_reset_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nx;
            clr_ptr <= ptr_nx;
        end
    end
    always_comb begin
        busy     = state == CLEAR;
        ptr_nx   = busy ? clr_ptr + 1'b1 : clr_ptr;
        state_nx = (busy && clr_ptr == LAST) ? READY : state;
    end
    assign sweep_we   = busy & gen_reset_n;
    assign sweep_addr = clr_ptr[ADDR_W-1:0];
endmodule

// File: rtl/ram_dp_be.sv
// ram_dp_be: byte-enabled read/write port A, read-only port B, cleared to INIT_VAL after reset
module ram_dp_be import ram_pkg::*; #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                       clk,
    input  logic                       gen_reset_n,
    input  logic                       write_enable,
    input  logic [DATA_W/BYTE_W-1:0]   byte_en,
    input  logic [ADDR_W-1:0]          adress_a,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out_a,
    input  logic                       rd_en_b,
    input  logic [ADDR_W-1:0]          adress_b,
    output logic [DATA_W-1:0]          data_out_b,
    output logic                       valid_b,
    output logic                       collision_b,
    output logic                       busy
);
    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;
    if (DATA_W % BYTE_W != 0) begin : g_bad_width
        $error("DATA_W must be a multiple of BYTE_W");
    end
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] lane_mask, merged;
    logic              sweep_we, wr_a, rd_b;
    logic [ADDR_W-1:0] sweep_addr;
    ram_init_fsm #(.ADDR_W(ADDR_W)) u_init (
        .clk        (clk),
        .gen_reset_n(gen_reset_n),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign lane_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{byte_en[i]}};
    end
    assign merged = DATA_W'(byte_merge(MAX_W'(mem[adress_a]), MAX_W'(data_in), MAX_W'(lane_mask)));
    assign wr_a   = !busy & write_enable & |byte_en;
    assign rd_b   = !busy & rd_en_b;
    always_ff @(posedge clk) begin
        if (sweep_we)
            mem[sweep_addr] <= INIT_VAL;
        else if (wr_a)
            mem[adress_a] <= merged;
    end
    // port B samples the array before this edge's write lands, giving read-before-write on a collision
    always_ff @(posedge clk) begin
        if (!gen_reset_n) begin
            data_out_a  <= '0;
            data_out_b  <= '0;
            valid_b     <= 1'b0;
            collision_b <= 1'b0;
        end else if (!busy) begin
            data_out_a  <= wr_a ? merged : mem[adress_a];
            data_out_b  <= rd_b ? mem[adress_b] : data_out_b;
            valid_b     <= rd_b;
            collision_b <= rd_b & wr_a & (adress_a == adress_b);
        end
    end
endmodule
